sad1_search_engine: RTL and testbench

Consumes one MEM→SAD1 pipeline-register payload (4×4 window, 11-row × 7-column frame patch, 16-bit index, trigger flag) and exhaustively scans all 32 candidate offsets of the window within the patch. It accumulates a 16-pixel SAD per candidate and tracks the minimum. It returns the best SAD and its offset over a ready/valid handshake. It sits directly downstream of the MEM/SAD1 pipeline register and replaces the combinational SAD1 stage with a sequential, area-lean engine.

---
 rtl/sad_pkg.sv | 29 ++
 rtl/sad4x4_abs_sum.sv | 28 ++
 rtl/sad1_search_engine.sv | 166 ++++++++++++++++
 tb/tb_sad1_search_engine.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared constants, FSM state type and pixel-index helpers for the SAD1 search engine.
package sad_pkg;

  localparam int PIX_W    = 9;
  localparam int SAD_W    = 13;
  localparam int WIN_DIM  = 4;
  localparam int FRM_ROWS = 11;
  localparam int FRM_COLS = 7;
  localparam int NUM_CAND = 32;
  localparam int WIN_PIX  = WIN_DIM * WIN_DIM;
  localparam int FRM_PIX  = FRM_ROWS * FRM_COLS;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  // Flat element index of window pixel (r,c).
  function automatic int win_idx(input int r, input int c);
    return r * WIN_DIM + c;
  endfunction

  // Flat element index of frame-patch pixel (row,col).
  function automatic int frm_idx(input int row, input int col);
    return row * FRM_COLS + col;
  endfunction

endpackage

// File: rtl/sad4x4_abs_sum.sv
// Combinational 16-pixel sum of absolute differences between a window and one candidate block.
module sad4x4_abs_sum
  import sad_pkg::*;
#(
  parameter int PIX_W = sad_pkg::PIX_W,
  parameter int SAD_W = sad_pkg::SAD_W
) (
  input  logic [WIN_PIX*PIX_W-1:0] win_i,
  input  logic [WIN_PIX*PIX_W-1:0] frm_i,
  output logic [SAD_W-1:0]         sad_o
);

  // Per-pixel magnitude of the difference taken in PIX_W+1 bits, then summed.
  always_comb begin
    logic [PIX_W:0] diff;
    logic [PIX_W:0] mag;
    // NOTE: every variable written here gets a value before any use, so no latch is inferred.
    sad_o = '0;
    diff  = '0;
    mag   = '0;
    for (int e = 0; e < WIN_PIX; e++) begin
      diff  = {1'b0, win_i[e*PIX_W +: PIX_W]} - {1'b0, frm_i[e*PIX_W +: PIX_W]};
      mag   = diff[PIX_W] ? (~diff + 1'b1) : diff;
      sad_o = sad_o + SAD_W'(mag);
    end
  end

endmodule

// File: rtl/sad1_search_engine.sv
// Sequential SAD1 stage: captures one payload, scans all 32 window offsets in the
// patch one per cycle, and returns the minimum SAD and its offset over ready/valid.
module sad1_search_engine
  import sad_pkg::*;
#(
  parameter int PIX_W = sad_pkg::PIX_W,
  parameter int SAD_W = sad_pkg::SAD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_trigger_boss,
  input  logic [15:0]              in_index,
  input  logic [WIN_PIX*PIX_W-1:0] in_window,
  input  logic [FRM_PIX*PIX_W-1:0] in_frame,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_trigger_boss,
  output logic [15:0]              out_index,
  output logic [SAD_W-1:0]         out_best_sad,
  output logic [2:0]               out_best_dy,
  output logic [1:0]               out_best_dx
);

  // Captured payload
  logic [WIN_PIX*PIX_W-1:0] window_q;
  logic [FRM_PIX*PIX_W-1:0] frame_q;
  logic [15:0]              index_q;
  logic                     trigger_q;

  // Control and best tracker
  state_e           state_q;
  logic [4:0]       cnt_q;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [2:0]       best_dy_q, best_dy_d;
  logic [1:0]       best_dx_q, best_dx_d;

  // Registered outputs
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_trigger_q;
  logic [15:0]      out_index_q;
  logic [SAD_W-1:0] out_sad_q;
  logic [2:0]       out_dy_q;
  logic [1:0]       out_dx_q;

  logic                     accept;
  logic [2:0]               cand_dy;
  logic [1:0]               cand_dx;
  logic [WIN_PIX*PIX_W-1:0] cand_pix;
  logic [SAD_W-1:0]         cand_sad;

  // in_ready_q is only ever high in IDLE, so it alone qualifies the handshake.
  assign accept  = in_valid & in_ready_q;
  assign cand_dy = cnt_q[4:2];
  assign cand_dx = cnt_q[1:0];

  // Payload capture on the accept edge; the bus is ignored at all other times.
  // NOTE: pure data registers are qualified by the FSM and need no reset, which keeps the wide capture flops cheap.
  always_ff @(posedge clk) begin
    if (accept) begin
      window_q  <= in_window;
      frame_q   <= in_frame;
      index_q   <= in_index;
      trigger_q <= in_trigger_boss;
    end
  end

  // Candidate mux: pick the 4x4 block of the patch at offset (cand_dy, cand_dx).
  always_comb begin
    cand_pix = '0;
    for (int r = 0; r < WIN_DIM; r++) begin
      for (int c = 0; c < WIN_DIM; c++) begin
        cand_pix[win_idx(r, c)*PIX_W +: PIX_W] =
          frame_q[frm_idx(int'(cand_dy) + r, int'(cand_dx) + c)*PIX_W +: PIX_W];
      end
    end
  end

  sad4x4_abs_sum #(
    .PIX_W (PIX_W),
    .SAD_W (SAD_W)
  ) u_abs_sum (
    .win_i (window_q),
    .frm_i (cand_pix),
    .sad_o (cand_sad)
  );

  // Best tracker: strict less-than so the earliest candidate wins ties.
  always_comb begin
    best_sad_d = best_sad_q;
    best_dy_d  = best_dy_q;
    best_dx_d  = best_dx_q;
    if (cand_sad < best_sad_q) begin
      best_sad_d = cand_sad;
      best_dy_d  = cand_dy;
      best_dx_d  = cand_dx;
    end
  end

  // FSM with registered handshake and result outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      best_sad_q    <= '1;
      best_dy_q     <= '0;
      best_dx_q     <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_trigger_q <= 1'b0;
      out_index_q   <= '0;
      out_sad_q     <= '0;
      out_dy_q      <= '0;
      out_dx_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            state_q    <= SCAN;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
            best_sad_q <= '1;
            best_dy_q  <= '0;
            best_dx_q  <= '0;
          end
        end
        SCAN: begin
          cnt_q      <= cnt_q + 5'd1;
          best_sad_q <= best_sad_d;
          best_dy_q  <= best_dy_d;
          best_dx_q  <= best_dx_d;
          if (cnt_q == 5'(NUM_CAND - 1)) begin
            state_q       <= DONE;
            out_valid_q   <= 1'b1;
            out_sad_q     <= best_sad_d;
            out_dy_q      <= best_dy_d;
            out_dx_q      <= best_dx_d;
            out_index_q   <= index_q;
            out_trigger_q <= trigger_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = out_valid_q;
  assign out_trigger_boss = out_trigger_q;
  assign out_index        = out_index_q;
  assign out_best_sad     = out_sad_q;
  assign out_best_dy      = out_dy_q;
  assign out_best_dx      = out_dx_q;

endmodule

// File: tb/tb_sad1_search_engine.sv
// Self-checking bench for sad1_search_engine: directed corner jobs plus random jobs
// compared against a brute-force SAD search model.
module tb_sad1_search_engine;
  import sad_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic                     in_trigger_boss = 1'b0;
  logic [15:0]              in_index = '0;
  logic [WIN_PIX*PIX_W-1:0] in_window = '0;
  logic [FRM_PIX*PIX_W-1:0] in_frame = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic                     out_trigger_boss;
  logic [15:0]              out_index;
  logic [SAD_W-1:0]         out_best_sad;
  logic [2:0]               out_best_dy;
  logic [1:0]               out_best_dx;

  int checks = 0;
  int failures = 0;

  int          w[WIN_PIX];
  int          f[FRM_PIX];
  logic [15:0] job_idx;
  logic        job_trig;
  int          exp_sad, exp_dy, exp_dx;

  always #5 clk = ~clk;

  sad1_search_engine dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_trigger_boss  (in_trigger_boss),
    .in_index         (in_index),
    .in_window        (in_window),
    .in_frame         (in_frame),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_trigger_boss (out_trigger_boss),
    .out_index        (out_index),
    .out_best_sad     (out_best_sad),
    .out_best_dy      (out_best_dy),
    .out_best_dx      (out_best_dx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Brute-force search over all offsets in scan order; strict < keeps the first minimum.
  task automatic model();
    int best, s, d;
    best = 1 << 30;
    exp_dy = 0;
    exp_dx = 0;
    for (int dy = 0; dy < 8; dy++) begin
      for (int dx = 0; dx < 4; dx++) begin
        s = 0;
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            d = w[r*4+c] - f[(dy+r)*7 + dx + c];
            s += (d < 0) ? -d : d;
          end
        end
        if (s < best) begin
          best = s;
          exp_dy = dy;
          exp_dx = dx;
        end
      end
    end
    exp_sad = best;
  endtask

  task automatic drive_bus();
    for (int e = 0; e < WIN_PIX; e++) in_window[e*PIX_W +: PIX_W] = PIX_W'(w[e]);
    for (int e = 0; e < FRM_PIX; e++) in_frame[e*PIX_W +: PIX_W] = PIX_W'(f[e]);
    in_index        = job_idx;
    in_trigger_boss = job_trig;
  endtask

  task automatic scramble();
    for (int e = 0; e < WIN_PIX; e++) in_window[e*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 511));
    for (int e = 0; e < FRM_PIX; e++) in_frame[e*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 511));
    in_index        = 16'($urandom);
    in_trigger_boss = ~job_trig;
  endtask

  task automatic fill(input int wmax, input int fmax);
    for (int e = 0; e < WIN_PIX; e++) w[e] = $urandom_range(0, wmax);
    for (int e = 0; e < FRM_PIX; e++) f[e] = $urandom_range(0, fmax);
    job_idx  = 16'($urandom);
    job_trig = 1'($urandom);
  endtask

  // Wait for in_ready, present the job for one accept edge, then scramble the bus.
  task automatic accept_job(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, in_ready, 1);
    drive_bus();
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic run_job(input string tag, input int hold);
    int lat;
    model();
    accept_job(tag);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 32);
    check({tag, "_sad"}, out_best_sad, exp_sad);
    check({tag, "_dy"}, out_best_dy, exp_dy);
    check({tag, "_dx"}, out_best_dx, exp_dx);
    check({tag, "_index"}, out_index, job_idx);
    check({tag, "_trig"}, out_trigger_boss, job_trig);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_ready"}, in_ready, 0);
      check({tag, "_hold_sad"}, out_best_sad, exp_sad);
      check({tag, "_hold_index"}, out_index, job_idx);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, out_valid, 0);
    check({tag, "_idle_ready"}, in_ready, 1);
    check({tag, "_kept_sad"}, out_best_sad, exp_sad);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sad", out_best_sad, 0);
    check("rst_index", out_index, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", in_ready, 0);
    @(negedge clk);
    check("rel_in_ready_high", in_ready, 1);

    // Zeros: ties keep the first candidate
    for (int e = 0; e < WIN_PIX; e++) w[e] = 0;
    for (int e = 0; e < FRM_PIX; e++) f[e] = 0;
    job_idx = 16'h0001; job_trig = 1'b0;
    run_job("zeros", 0);

    // Exact match planted at dy=5, dx=2
    for (int e = 0; e < WIN_PIX; e++) w[e] = e + 1;
    for (int e = 0; e < FRM_PIX; e++) f[e] = 511;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) f[(5+r)*7 + 2 + c] = r*4 + c + 1;
    job_idx = 16'h1234; job_trig = 1'b1;
    run_job("match", 0);
    check("match_ref_dy", exp_dy, 5);
    check("match_ref_sad", exp_sad, 0);

    // Max magnitude
    for (int e = 0; e < WIN_PIX; e++) w[e] = 511;
    for (int e = 0; e < FRM_PIX; e++) f[e] = 0;
    job_idx = 16'h00FF; job_trig = 1'b0;
    run_job("maxmag", 0);
    check("maxmag_ref_sad", exp_sad, 8176);

    // Backpressure then an immediate second job
    fill(511, 511);
    run_job("bp", 10);
    fill(511, 511);
    run_job("bp_next", 0);

    // Pass-through of index and trigger while the bus changes during the scan
    fill(511, 511);
    job_idx = 16'hBEEF; job_trig = 1'b1;
    run_job("pass", 2);

    // Reset mid-scan with non-zero outputs from the previous job still held
    for (int e = 0; e < WIN_PIX; e++) w[e] = e + 1;
    for (int e = 0; e < FRM_PIX; e++) f[e] = 511;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) f[(5+r)*7 + 2 + c] = r*4 + c + 1;
    job_idx = 16'hA5A5; job_trig = 1'b1;
    run_job("pre_rst", 0);
    fill(511, 511);
    accept_job("midrst");
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_sad", out_best_sad, 0);
    check("midrst_dy", out_best_dy, 0);
    check("midrst_dx", out_best_dx, 0);
    check("midrst_index", out_index, 0);
    check("midrst_trig", out_trigger_boss, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_release_ready", in_ready, 1);
    fill(511, 511);
    run_job("post_rst", 0);

    // Random jobs, some with small ranges to force many ties
    for (int j = 0; j < 8; j++) begin
      if (j % 2 == 0) fill(511, 511);
      else fill(3, 3);
      run_job($sformatf("rand%0d", j), j % 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
